// File: rtl/fpnew_issue_rob.sv
// Issue/reorder front-end for FPNew: tags commands on issue, gathers out-of-order
// completions by tag and retires them to the core strictly in issue order.
module fpnew_issue_rob #(
    parameter int FLEN       = 64,
    parameter int TAG_WIDTH  = 3,
    parameter int CTRL_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [3*FLEN-1:0]     cmd_operands_i,
    input  logic [CTRL_WIDTH-1:0] cmd_ctrl_i,
    output logic                  fpu_in_valid_o,
    input  logic                  fpu_in_ready_i,
    output logic [3*FLEN-1:0]     fpu_operands_o,
    output logic [CTRL_WIDTH-1:0] fpu_ctrl_o,
    output logic [TAG_WIDTH-1:0]  fpu_tag_o,
    output logic                  fpu_flush_o,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    input  logic [FLEN-1:0]       fpu_result_i,
    input  logic [4:0]            fpu_status_i,
    input  logic [TAG_WIDTH-1:0]  fpu_tag_i,
    input  logic                  fpu_busy_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [FLEN-1:0]       rsp_result_o,
    output logic [4:0]            rsp_status_o,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  spurious_o
);
    localparam int DEPTH = 2 ** TAG_WIDTH;

    logic [DEPTH-1:0]           pending_q, pending_d;
    logic [DEPTH-1:0]           done_q, done_d;
    logic [DEPTH-1:0][FLEN-1:0] result_q;
    logic [DEPTH-1:0][4:0]      status_q;
    logic [TAG_WIDTH-1:0]       head_q, head_d, tail_q, tail_d;
    logic [TAG_WIDTH:0]         count_q, count_d;
    logic                       spurious_q, spurious_d;
    logic                       full, alloc, retire, cmpl_hit, cmpl_ok;

    assign full           = (count_q == (TAG_WIDTH+1)'(DEPTH));
    assign fpu_in_valid_o = cmd_valid_i & ~full & ~flush_i;
    assign cmd_ready_o    = fpu_in_ready_i & ~full & ~flush_i;
    assign fpu_operands_o = cmd_operands_i;
    assign fpu_ctrl_o     = cmd_ctrl_i;
    assign fpu_tag_o      = tail_q;
    assign fpu_flush_o    = flush_i;
    assign fpu_out_ready_o = 1'b1;

    assign rsp_valid_o  = done_q[head_q];
    assign rsp_result_o = result_q[head_q];
    assign rsp_status_o = status_q[head_q];
    assign busy_o       = (count_q != '0) | fpu_busy_i;
    assign spurious_o   = spurious_q;

    assign alloc    = fpu_in_valid_o & fpu_in_ready_i;
    assign retire   = rsp_valid_o & rsp_ready_i & ~flush_i;
    assign cmpl_hit = pending_q[fpu_tag_i] & ~done_q[fpu_tag_i];
    assign cmpl_ok  = fpu_out_valid_i & ~flush_i & cmpl_hit;
    // Flush-caused drops are intentional, so they never flag as spurious.
    assign spurious_d = fpu_out_valid_i & ~flush_i & ~cmpl_hit;

    always_comb begin
        pending_d = pending_q;
        done_d    = done_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (alloc) begin
            pending_d[tail_q] = 1'b1;
            done_d[tail_q]    = 1'b0;
            tail_d            = tail_q + 1'b1;
        end
        if (retire) begin
            pending_d[head_q] = 1'b0;
            done_d[head_q]    = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (cmpl_ok) done_d[fpu_tag_i] = 1'b1;
        case ({alloc, retire})
            2'b10:   count_d = count_q + (TAG_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (TAG_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            pending_d = '0;
            done_d    = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            done_q     <= '0;
            result_q   <= '0;
            status_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
            if (cmpl_ok) begin
                result_q[fpu_tag_i] <= fpu_result_i;
                status_q[fpu_tag_i] <= fpu_status_i;
            end
        end
    end
endmodule

// File: tb/tb_fpnew_issue_rob.sv
// Directed bench for fpnew_issue_rob: issue, out-of-order completion, full/wrap,
// backpressure, flush, spurious completion and asynchronous reset.
module tb_fpnew_issue_rob;
    localparam int FLEN = 64, TW = 3, CW = 17;

    logic            clk_i = 1'b0, rst_ni = 1'b0;
    logic            cmd_valid_i = 1'b0, cmd_ready_o;
    logic [3*FLEN-1:0] cmd_operands_i = '0;
    logic [CW-1:0]   cmd_ctrl_i = '0;
    logic            fpu_in_valid_o, fpu_in_ready_i = 1'b1;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [CW-1:0]   fpu_ctrl_o;
    logic [TW-1:0]   fpu_tag_o;
    logic            fpu_flush_o;
    logic            fpu_out_valid_i = 1'b0, fpu_out_ready_o;
    logic [FLEN-1:0] fpu_result_i = '0;
    logic [4:0]      fpu_status_i = '0;
    logic [TW-1:0]   fpu_tag_i = '0;
    logic            fpu_busy_i = 1'b0;
    logic            rsp_valid_o, rsp_ready_i = 1'b0;
    logic [FLEN-1:0] rsp_result_o;
    logic [4:0]      rsp_status_o;
    logic            flush_i = 1'b0, busy_o, spurious_o;

    int n_checks = 0, n_fails = 0;

    fpnew_issue_rob #(.FLEN(FLEN), .TAG_WIDTH(TW), .CTRL_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_operands_i(cmd_operands_i), .cmd_ctrl_i(cmd_ctrl_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_ctrl_o(fpu_ctrl_o),
        .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .fpu_tag_i(fpu_tag_i), .fpu_busy_i(fpu_busy_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .flush_i(flush_i), .busy_o(busy_o), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; fpu_out_valid_i = 1'b0; rsp_ready_i = 1'b0;
        flush_i = 1'b0; fpu_busy_i = 1'b0; fpu_in_ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid_i = 1'b1;
            cmd_operands_i = {3{64'(i + 100)}};
            cmd_ctrl_i = CW'(i + 7);
            tick();
        end
        cmd_valid_i = 1'b0;
        #1;
    endtask

    task automatic complete(input logic [TW-1:0] tag, input logic [63:0] res, input logic [4:0] st);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i = tag; fpu_result_i = res; fpu_status_i = st;
        tick();
        fpu_out_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_result", rsp_result_o, 64'd0);
        chk("rst_rsp_status", 64'(rsp_status_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_spurious", 64'(spurious_o), 64'd0);
        chk("out_ready_const", 64'(fpu_out_ready_o), 64'd1);
        do_reset();

        // Single op: issue at cycle 0, completion at cycle 3, response at cycle 4
        cmd_valid_i = 1'b1;
        cmd_operands_i = {64'h3, 64'h2, 64'h1};
        cmd_ctrl_i = 17'h1ABCD;
        #1;
        chk("single_in_valid", 64'(fpu_in_valid_o), 64'd1);
        chk("single_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("single_tag", 64'(fpu_tag_o), 64'd0);
        chk("single_ops", fpu_operands_o[127:64], 64'h2);
        chk("single_ctrl", 64'(fpu_ctrl_o), 64'h1ABCD);
        tick();
        cmd_valid_i = 1'b0;
        chk("single_busy", 64'(busy_o), 64'd1);
        tick();
        tick();
        fpu_out_valid_i = 1'b1; fpu_tag_i = 3'd0;
        fpu_result_i = 64'h3FF0000000000000; fpu_status_i = 5'b00001;
        #1;
        chk("single_no_bypass", 64'(rsp_valid_o), 64'd0);
        tick();
        fpu_out_valid_i = 1'b0;
        chk("single_rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("single_rsp_result", rsp_result_o, 64'h3FF0000000000000);
        chk("single_rsp_status", 64'(rsp_status_o), 64'h1);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("single_retired", 64'(rsp_valid_o), 64'd0);
        chk("single_idle", 64'(busy_o), 64'd0);

        // Out-of-order completion
        do_reset();
        issue(3);
        complete(3'd2, 64'hA, 5'd2);
        chk("ooo_wait_head", 64'(rsp_valid_o), 64'd0);
        complete(3'd0, 64'hB, 5'd0);
        chk("ooo_head_done", 64'(rsp_valid_o), 64'd1);
        complete(3'd1, 64'hC, 5'd1);
        rsp_ready_i = 1'b1;
        #1;
        chk("ooo_r0", rsp_result_o, 64'hB);
        tick();
        chk("ooo_r1_valid", 64'(rsp_valid_o), 64'd1);
        chk("ooo_r1", rsp_result_o, 64'hC);
        tick();
        chk("ooo_r2", rsp_result_o, 64'hA);
        chk("ooo_r2_status", 64'(rsp_status_o), 64'd2);
        tick();
        rsp_ready_i = 1'b0;
        chk("ooo_drained", 64'(rsp_valid_o), 64'd0);
        chk("ooo_idle", 64'(busy_o), 64'd0);

        // Full and wrap
        do_reset();
        issue(8);
        cmd_valid_i = 1'b1;
        #1;
        chk("full_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("full_in_valid", 64'(fpu_in_valid_o), 64'd0);
        complete(3'd0, 64'h55, 5'd3);
        rsp_ready_i = 1'b1;
        #1;
        chk("full_retire_valid", 64'(rsp_valid_o), 64'd1);
        chk("full_blocks_with_retire", 64'(cmd_ready_o), 64'd0);
        tick();
        rsp_ready_i = 1'b0;
        #1;
        chk("wrap_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("wrap_tag", 64'(fpu_tag_o), 64'd0);
        tick();
        chk("wrap_full_again", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b0;

        // Response backpressure
        do_reset();
        issue(4);
        for (int i = 0; i < 4; i++) begin
            complete(3'(i), 64'(16 + i), 5'(i + 4));
            chk("bp_valid_held", 64'(rsp_valid_o), 64'd1);
            chk("bp_head_stable", rsp_result_o, 64'h10);
        end
        rsp_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_result", rsp_result_o, 64'(16 + i));
            chk("bp_status", 64'(rsp_status_o), 64'(i + 4));
            tick();
        end
        rsp_ready_i = 1'b0;
        chk("bp_drained", 64'(rsp_valid_o), 64'd0);

        // Flush with a coincident completion
        do_reset();
        issue(3);
        flush_i = 1'b1; cmd_valid_i = 1'b1; fpu_busy_i = 1'b1;
        fpu_out_valid_i = 1'b1; fpu_tag_i = 3'd1; fpu_result_i = 64'hDEAD;
        #1;
        chk("flush_passthru", 64'(fpu_flush_o), 64'd1);
        chk("flush_no_accept", 64'(cmd_ready_o), 64'd0);
        chk("flush_no_issue", 64'(fpu_in_valid_o), 64'd0);
        tick();
        flush_i = 1'b0; cmd_valid_i = 1'b0; fpu_out_valid_i = 1'b0;
        chk("flush_no_spurious", 64'(spurious_o), 64'd0);
        chk("flush_busy_fpu", 64'(busy_o), 64'd1);
        chk("flush_rsp_cleared", 64'(rsp_valid_o), 64'd0);
        fpu_busy_i = 1'b0;
        #1;
        chk("flush_count_zero", 64'(busy_o), 64'd0);
        chk("flush_next_tag", 64'(fpu_tag_o), 64'd0);

        // Spurious completion, then asynchronous reset mid-stream
        do_reset();
        issue(2);
        complete(3'd5, 64'h99, 5'd1);
        chk("spur_pulse", 64'(spurious_o), 64'd1);
        chk("spur_no_rsp", 64'(rsp_valid_o), 64'd0);
        tick();
        chk("spur_one_cycle", 64'(spurious_o), 64'd0);
        complete(3'd0, 64'h77, 5'd8);
        chk("spur_then_valid", 64'(rsp_valid_o), 64'd1);
        chk("spur_then_result", rsp_result_o, 64'h77);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("arst_rsp_result", rsp_result_o, 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_tag", 64'(fpu_tag_o), 64'd0);
        tick();
        rst_ni = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fpnew_issue_rob.md
Name: fpnew_issue_rob

Overview:
- Initiator-side companion to the FPNew wrapper. It accepts FP commands from the core, assigns tags and drives the FPU input handshake.
- FPNew can return results out of order across operation groups. This block collects them by tag in a reorder buffer and hands them back to the core strictly in issue order.
- Sits between the core's FP dispatch stage and the FPNew wrapper instance.

Parameters:
- FLEN, 64, operand/result width; must match the wrapper's FLEN.
- TAG_WIDTH, 3, tag width. ROB depth DEPTH = 2**TAG_WIDTH.
- CTRL_WIDTH, 17, opaque packed FPU control bundle (rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial). The parent packs and unpacks it; this block passes it through unmodified.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  core command valid
- cmd_ready_o  out  1  command accepted this cycle
- cmd_operands_i  in  3*FLEN  operands {op2,op1,op0}
- cmd_ctrl_i  in  CTRL_WIDTH  control bundle
- fpu_in_valid_o  out  1  to wrapper in_valid_i
- fpu_in_ready_i  in  1  from wrapper in_ready_o
- fpu_operands_o  out  3*FLEN  to wrapper operands_i
- fpu_ctrl_o  out  CTRL_WIDTH  to wrapper control inputs
- fpu_tag_o  out  TAG_WIDTH  to wrapper tag_i
- fpu_flush_o  out  1  to wrapper flush_i
- fpu_out_valid_i  in  1  from wrapper out_valid_o
- fpu_out_ready_o  out  1  to wrapper out_ready_i
- fpu_result_i  in  FLEN  from wrapper result_o
- fpu_status_i  in  5  from wrapper status_o {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TAG_WIDTH  from wrapper tag_o
- fpu_busy_i  in  1  from wrapper busy_o
- rsp_valid_o  out  1  in-order response valid
- rsp_ready_i  in  1  core accepts response
- rsp_result_o  out  FLEN  result
- rsp_status_o  out  5  exception flags
- flush_i  in  1  core pipeline flush
- busy_o  out  1  work outstanding
- spurious_o  out  1  one-cycle pulse: completion for a non-pending tag

Behaviour:
- State:
  - Per entry: pending, done, result[FLEN], status[5].
  - head pointer and tail pointer, TAG_WIDTH bits each, wrapping naturally.
  - count, TAG_WIDTH+1 bits. full = (count == DEPTH).
- Reset (async, rst_ni low):
  - head, tail and count are 0; all pending/done bits are 0.
  - spurious_o = 0. rsp_valid_o = 0; rsp_result_o and rsp_status_o are 0 (entry storage is reset).
- Issue path (combinational, zero latency):
  - fpu_in_valid_o = cmd_valid_i & !full & !flush_i.
  - cmd_ready_o = fpu_in_ready_i & !full & !flush_i.
  - fpu_operands_o = cmd_operands_i; fpu_ctrl_o = cmd_ctrl_i; fpu_tag_o = tail.
  - On fire (fpu_in_valid_o & fpu_in_ready_i): entry[tail].pending <= 1, done <= 0; tail <= tail+1.
  - fpu_in_valid_o never depends on fpu_in_ready_i.
- Completion path:
  - fpu_out_ready_o is constant 1. Every issued op owns an entry, so there is never backpressure.
  - On fpu_out_valid_i with entry[fpu_tag_i].pending & !done: store result and status, set done <= 1.
  - If the tag is not pending or already done: drop the completion and pulse spurious_o the next cycle. No state changes.
- Retire path:
  - rsp_valid_o = entry[head].done, driven from registers.
  - rsp_result_o and rsp_status_o come from entry[head].
  - On rsp_valid_o & rsp_ready_i: clear pending and done of head; head <= head+1.
  - While rsp_ready_i is low, outputs stay stable.
- Latency:
  - A completion updates done at the clock edge, so rsp_valid_o rises the cycle after fpu_out_valid_i.
  - Minimum cmd fire to rsp_valid_o = FPU latency + 1. There is no completion-to-response bypass.
- Simultaneous events:
  - Alloc and retire in the same cycle: count unchanged.
  - Full blocks alloc even if a retire occurs that cycle; alloc resumes the next cycle.
  - A completion to tag X and a retire of head != X in the same cycle are independent.
  - A completion to head and alloc at the same tail index cannot coincide, because full prevents it.
- Flush (flush_i high for one or more cycles):
  - fpu_flush_o = flush_i, combinational.
  - No command is accepted and completions in that cycle are dropped. spurious_o does not pulse for drops caused by flush.
  - Next cycle: head = tail = count = 0, all bits cleared.
  - rsp_valid_o may show the current head during the flush cycle, but a retire in that cycle is ignored. The parent must not treat it as a response.
  - Post-flush stale completions are excluded by the FPNew flush contract.
- busy_o = (count != 0) | fpu_busy_i.
- Reset mid-operation clears everything immediately (asynchronous). Outputs return to their reset values.

Test Plan:
- Single op: fire cmd with tag 0 at cycle 0; FPU returns result 0x3FF0000000000000 with status 5'b00001 and tag 0 at cycle 3 -> rsp_valid_o at cycle 4 with the same result/status; busy_o low after retire.
- Out-of-order: issue tags 0,1,2; FPU returns tag 2 (0xA), then 0 (0xB), then 1 (0xC) -> rsp_valid_o stays low until tag 0 lands; responses come out as 0xB, 0xC, 0xA on consecutive cycles with rsp_ready_i=1.
- Full/wrap: DEPTH=8, issue 8 ops with no completions -> 9th cycle cmd_ready_o=0 and fpu_in_valid_o=0; complete and retire tag 0 -> the next command is accepted one cycle later with fpu_tag_o=0.
- Backpressure: rsp_ready_i=0 while 4 completions arrive -> rsp_valid_o=1 with the head data held stable; then rsp_ready_i=1 for 4 cycles -> 4 in-order responses.
- Flush: 3 outstanding, a completion for tag 1 arrives in the same cycle as flush_i -> fpu_flush_o=1 and the completion is dropped; next cycle count=0 and busy_o tracks fpu_busy_i; the next command gets tag 0.
- Spurious/reset: completion with tag 5 when only tags 0,1 are pending -> spurious_o pulses 1 cycle and there is no rsp change; asserting rst_ni low mid-stream -> all outputs go to their reset values immediately.
